fp_align_pipe: RTL and testbench
================================

# fp_align_pipe

Two-stage elastic alignment pipeline for the double-precision adder. It sits directly upstream of the sticky-bit logic and the significand adder. It orders the two operands by exponent, computes the clamped alignment shift, right-shifts the smaller significand, and produces the sticky bit. Each stage is held behind a valid/ready handshake so the adder datapath can stall without losing operands.

## Interface
- EXP_W, 11, exponent width
- FRAC_W, 52, stored fraction width; aligned significand width is FRAC_W+3 = 55 (hidden bit, fraction, guard, round)
- SH_W, 6, shift-amount width; shift clamps to 2**SH_W-1 = 63
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of both stages (reset-like, datapath untouched)
- in_valid  in  1  operand pair offered
- in_ready  out  1  pipeline accepts pair this cycle
- ea, eb  in  EXP_W  biased exponents
- fa, fb  in  FRAC_W  stored fractions
- sa, sb  in  1  signs
- sub  in  1  operation is subtract
- out_valid  out  1  aligned result available
- out_ready  in  1  downstream consumes result
- es  out  EXP_W  larger effective exponent
- fa_al  out  55  larger significand {hidden, frac, 2'b00}
- fb_al  out  55  smaller significand, right-shifted by as2
- as2  out  SH_W  applied shift amount
- sticky  out  1  OR of all bits shifted out of fb_al
- swap  out  1  operands were exchanged (b larger)
- sl, eff_sub  out  1  sign of larger operand; sa^sb^sub

## Operation
- Operand normalisation: hidden = (e != 0); effective exponent = (e == 0) ? 1 : e (subnormals).
- Stage 1 (S1): 12-bit signed diff = eA_eff - eB_eff. swap = diff < 0 (exponent-only compare; an equal exponent gives swap=0). as2 = min(|diff|, 63). Registers the ordered significands, es, sl, eff_sub, swap, as2.
- Stage 2 (S2): x = {hidden_s, frac_s, 2'b00}; fb_al = x >> as2; sticky = |(x & ((1<<as2)-1)). If as2 ≥ 55, fb_al = 0 and sticky = |x. Registers all outputs.
- Handshake: a stage loads when empty or when its contents move on this cycle. out_valid = S2 valid. S2 advances when !S2_valid || out_ready. in_ready = !S1_valid || S2 advances. The pipeline holds two entries with no bubbles at full throughput.
- Output data is stable while out_valid && !out_ready. Results leave in issue order.
- rst or flush: S1_valid = S2_valid = 0 on the next edge. Data registers are don't-care. Any operand offered in that cycle is dropped. rst takes precedence over any simultaneous handshake.
- Reset values: out_valid 0, in_ready 1 (combinational, follows the empty pipe), es/fa_al/fb_al/as2 0, sticky/swap/sl/eff_sub 0.

## Timing
- Latency: 2 cycles from an accepted in_valid&&in_ready edge to out_valid.
- Throughput: 1 result per cycle while out_ready=1.
- in_ready depends combinationally on out_ready, which is the single combinational path. No path runs from in_* to out_*.
- Simultaneous accept and drain in the same cycle is legal at both stages.

## Configuration
- FP_ALIGN_STICKY_EN defined: sticky computed as above.
- FP_ALIGN_STICKY_EN undefined: sticky output tied to 0 and no OR-reduce logic is generated. This mode supports truncate-only adder builds. fb_al is unchanged.

## Structure
- Shared package fp_pkg holds EXP_W, FRAC_W, SIG_W (=55), SH_W, and a packed typedef align_t (es, fa_al, fb_al, as2, sticky, swap, sl, eff_sub) used for the S2 register and downstream ports.
- One sub-module: align_shift_right, a combinational barrel shift of 55 bits by SH_W with sticky output. It is instantiated in S2 and is the only place the macro is tested.

## Test plan
- ea=0x400, eb=0x3FE, fa=fb=0 -> swap 0, es 0x400, as2 2, fb_al = 1<<52, sticky 0, out_valid 2 cycles after accept.
- ea=0x402, eb=0x3FF, fb=1 -> as2 3, fb_al = 1<<51, sticky 1; with FP_ALIGN_STICKY_EN undefined the same input gives sticky 0.
- ea=0x3FF, eb=0x401, sa=0, sb=1, sub=0 -> swap 1, es 0x401, as2 2, sl 1, eff_sub 1.
- ea=0x7FE, eb=0x001, fb=0 -> as2 63, fb_al 0, sticky 1; ea=0, eb=0 -> hidden bits 0, as2 0, es 1.
- Three back-to-back inputs with out_ready=0 for 4 cycles -> in_ready low after 2 accepts, third held; out_ready=1 then drains all three in order on consecutive cycles.
- rst asserted with both stages full -> out_valid 0 and in_ready 1 next cycle, no stale output; flush behaves identically.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared widths and the aligned-operand record for the double-precision adder front end.
package fp_pkg;
    localparam int EXP_W  = 11;
    localparam int FRAC_W = 52;
    localparam int SIG_W  = FRAC_W + 3;
    localparam int SH_W   = 6;
    localparam int SH_MAX = 2**SH_W - 1;

    typedef struct packed {
        logic [EXP_W-1:0] es;
        logic [SIG_W-1:0] fa_al;
        logic [SIG_W-1:0] fb_al;
        logic [SH_W-1:0]  as2;
        logic             sticky;
        logic             swap;
        logic             sl;
        logic             eff_sub;
    } align_t;

    // Subnormals behave as exponent 1 with a zero hidden bit.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction
endpackage

// File: rtl/align_shift_right.sv
// Combinational right shift of the smaller significand with optional sticky OR-reduce.
// Latency 0; no handshake. Sticky logic exists only when FP_ALIGN_STICKY_EN is defined.
module align_shift_right
    import fp_pkg::*;
(
    input  logic [SIG_W-1:0] x,
    input  logic [SH_W-1:0]  sh,
    output logic [SIG_W-1:0] y,
    output logic             sticky
);
    // Shifts of SIG_W or more leave zero, which the language semantics already give.
    assign y = x >> sh;

`ifdef FP_ALIGN_STICKY_EN
    logic [SIG_W-1:0] mask;
    assign mask   = (sh >= SH_W'(SIG_W)) ? '1 : ((SIG_W'(1) << sh) - SIG_W'(1));
    assign sticky = |(x & mask);
`else
    assign sticky = 1'b0;
`endif
endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage elastic exponent compare / significand alignment ahead of the adder (sticky via FP_ALIGN_STICKY_EN).
// Latency 2 cycles, 1 result/cycle. Backpressure: out_ready stalls S2, a full S2 stalls S1; in_ready = !s1_vld || s2_adv.
module fp_align_pipe
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  ea,
    input  logic [EXP_W-1:0]  eb,
    input  logic [FRAC_W-1:0] fa,
    input  logic [FRAC_W-1:0] fb,
    input  logic              sa,
    input  logic              sb,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  es,
    output logic [SIG_W-1:0]  fa_al,
    output logic [SIG_W-1:0]  fb_al,
    output logic [SH_W-1:0]   as2,
    output logic              sticky,
    output logic              swap,
    output logic              sl,
    output logic              eff_sub
);
    logic             s1_vld, s2_vld, s2_adv;
    logic [EXP_W-1:0] ea_e, eb_e, mag;
    logic             swap_c;
    logic [SH_W-1:0]  as2_c;
    logic [SIG_W-1:0] sig_a, sig_b;

    logic [EXP_W-1:0] s1_es;
    logic [SIG_W-1:0] s1_big, s1_small;
    logic [SH_W-1:0]  s1_as2;
    logic             s1_swap, s1_sl, s1_eff_sub;

    align_t           s2, s2_d;
    logic [SIG_W-1:0] sh_y;
    logic             sh_sticky;

    assign s2_adv   = !s2_vld || out_ready;
    assign in_ready = !s1_vld || s2_adv;

    assign ea_e   = eff_exp(ea);
    assign eb_e   = eff_exp(eb);
    assign sig_a  = {ea != '0, fa, 2'b00};
    assign sig_b  = {eb != '0, fb, 2'b00};
    assign swap_c = eb_e > ea_e;
    assign mag    = swap_c ? (eb_e - ea_e) : (ea_e - eb_e);
    assign as2_c  = (mag > EXP_W'(SH_MAX)) ? '1 : mag[SH_W-1:0];

    // S1 data carries no reset: it is only observed behind s1_vld.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_es      <= swap_c ? eb_e : ea_e;
            s1_big     <= swap_c ? sig_b : sig_a;
            s1_small   <= swap_c ? sig_a : sig_b;
            s1_as2     <= as2_c;
            s1_swap    <= swap_c;
            s1_sl      <= swap_c ? sb : sa;
            s1_eff_sub <= sa ^ sb ^ sub;
        end
    end

    align_shift_right u_shift (
        .x      (s1_small),
        .sh     (s1_as2),
        .y      (sh_y),
        .sticky (sh_sticky)
    );

    always_comb begin
        s2_d         = '0;
        s2_d.es      = s1_es;
        s2_d.fa_al   = s1_big;
        s2_d.fb_al   = sh_y;
        s2_d.as2     = s1_as2;
        s2_d.sticky  = sh_sticky;
        s2_d.swap    = s1_swap;
        s2_d.sl      = s1_sl;
        s2_d.eff_sub = s1_eff_sub;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s2     <= '0;
        end else if (flush) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (in_ready) s1_vld <= in_valid;
            if (s2_adv)   s2_vld <= s1_vld;
            if (s2_adv && s1_vld) s2 <= s2_d;
        end
    end

    assign out_valid = s2_vld;
    assign es        = s2.es;
    assign fa_al     = s2.fa_al;
    assign fb_al     = s2.fb_al;
    assign as2       = s2.as2;
    assign sticky    = s2.sticky;
    assign swap      = s2.swap;
    assign sl        = s2.sl;
    assign eff_sub   = s2.eff_sub;
endmodule

// File: tb/tb_fp_align_pipe.sv
// Self-checking bench for fp_align_pipe: directed table, backpressure/reset/flush sequences, random stream vs arithmetic model.
module tb_fp_align_pipe;
    import fp_pkg::*;

`ifdef FP_ALIGN_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [EXP_W-1:0]  ea, eb, es;
    logic [FRAC_W-1:0] fa, fb;
    logic              sa, sb, sub;
    logic [SIG_W-1:0]  fa_al, fb_al;
    logic [SH_W-1:0]   as2;
    logic              sticky, swap, sl, eff_sub;
    align_t            got;

    int n_cmp = 0;
    int n_err = 0;
    align_t q[$];
    logic   hold_pend = 1'b0;
    align_t held;

    always #5 clk = ~clk;

    fp_align_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ea(ea), .eb(eb), .fa(fa), .fb(fb), .sa(sa), .sb(sb), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .es(es), .fa_al(fa_al), .fb_al(fb_al), .as2(as2),
        .sticky(sticky), .swap(swap), .sl(sl), .eff_sub(eff_sub)
    );

    always_comb got = {es, fa_al, fb_al, as2, sticky, swap, sl, eff_sub};

    typedef struct {
        logic [EXP_W-1:0]  ea, eb;
        logic [FRAC_W-1:0] fa, fb;
        logic              sa, sb, sub;
        align_t            exp;
    } vec_t;

    function automatic align_t mk(input logic [EXP_W-1:0] e, input logic [SIG_W-1:0] xl,
                                  input logic [SIG_W-1:0] xs, input int sh,
                                  input logic st, input logic sw, input logic s, input logic es_);
        align_t r;
        r.es = e; r.fa_al = xl; r.fb_al = xs; r.as2 = SH_W'(sh);
        r.sticky = st; r.swap = sw; r.sl = s; r.eff_sub = es_;
        return r;
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    function automatic align_t model(input logic [EXP_W-1:0] a_e, input logic [EXP_W-1:0] b_e,
                                     input logic [FRAC_W-1:0] a_f, input logic [FRAC_W-1:0] b_f,
                                     input logic a_s, input logic b_s, input logic op);
        int da, db, d, shv;
        longint unsigned xa, xb, xl, xs, fbv;
        logic st;
        align_t r;
        da = (a_e == 0) ? 1 : int'(a_e);
        db = (b_e == 0) ? 1 : int'(b_e);
        xa = (64'(a_f) << 2) + ((a_e != 0) ? (64'd1 << 54) : 64'd0);
        xb = (64'(b_f) << 2) + ((b_e != 0) ? (64'd1 << 54) : 64'd0);
        r.swap = db > da;
        d   = r.swap ? db - da : da - db;
        shv = (d > 63) ? 63 : d;
        xl  = r.swap ? xb : xa;
        xs  = r.swap ? xa : xb;
        if (shv >= 55) begin
            fbv = 0;
            st  = xs != 0;
        end else begin
            fbv = xs >> shv;
            st  = (xs % (64'd1 << shv)) != 0;
        end
        r.es      = EXP_W'(r.swap ? db : da);
        r.fa_al   = xl[SIG_W-1:0];
        r.fb_al   = fbv[SIG_W-1:0];
        r.as2     = SH_W'(shv);
        r.sticky  = st & STK;
        r.sl      = r.swap ? b_s : a_s;
        r.eff_sub = a_s ^ b_s ^ op;
        return r;
    endfunction

    task automatic chk(input string nm, input align_t g, input align_t e);
        n_cmp++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", nm, g, e);
        end
    endtask

    task automatic chk1(input string nm, input logic [63:0] g, input logic [63:0] e);
        n_cmp++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", nm, g, e);
        end
    endtask

    // Scoreboard: accepted pairs queued in order, every output transfer compared, stalls must hold data.
    always @(negedge clk) begin
        if (rst || flush) begin
            q.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk1("hold_valid", out_valid, 1);
                chk("hold_data", got, held);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk1("unexpected_out", 1, 0);
                else chk("stream", got, q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(ea, eb, fa, fb, sa, sb, sub));
            hold_pend = out_valid && !out_ready;
            held = got;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input vec_t v);
        ea = v.ea; eb = v.eb; fa = v.fa; fb = v.fb; sa = v.sa; sb = v.sb; sub = v.sub;
    endtask

    vec_t tbl[9];

    task automatic fill_full();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load(tbl[i]);
            in_valid = 1'b1;
            step();
        end
    endtask

    task automatic clear_check(input bit use_rst);
        int seen;
        fill_full();
        load(tbl[3]);
        in_valid = 1'b1;
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk1(use_rst ? "rst_out_valid" : "flush_out_valid", out_valid, 0);
        chk1(use_rst ? "rst_in_ready" : "flush_in_ready", in_ready, 1);
        if (use_rst) chk("rst_data_zero", got, '0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk1(use_rst ? "rst_no_stale" : "flush_no_stale", seen, 0);
    endtask

    initial begin
        int k, acc, fires, rdy_last;
        int unsigned off;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ea = '0; eb = '0; fa = '0; fb = '0; sa = 0; sb = 0; sub = 0;

        tbl[0] = '{11'h400, 11'h3FE, 52'd0, 52'd0, 1'b0, 1'b0, 1'b0,
                   mk(11'h400, 55'd1 << 54, 55'd1 << 52, 2, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[1] = '{11'h402, 11'h3FF, 52'd0, 52'd1, 1'b0, 1'b0, 1'b0,
                   mk(11'h402, 55'd1 << 54, 55'd1 << 51, 3, STK, 1'b0, 1'b0, 1'b0)};
        tbl[2] = '{11'h3FF, 11'h401, 52'd0, 52'd0, 1'b0, 1'b1, 1'b0,
                   mk(11'h401, 55'd1 << 54, 55'd1 << 52, 2, 1'b0, 1'b1, 1'b1, 1'b1)};
        tbl[3] = '{11'h7FE, 11'h001, 52'd0, 52'd0, 1'b0, 1'b0, 1'b0,
                   mk(11'h7FE, 55'd1 << 54, 55'd0, 63, STK, 1'b0, 1'b0, 1'b0)};
        tbl[4] = '{11'h000, 11'h000, 52'd5, 52'd3, 1'b0, 1'b0, 1'b0,
                   mk(11'h001, 55'd20, 55'd12, 0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[5] = '{11'h437, 11'h400, 52'd0, 52'd0, 1'b0, 1'b0, 1'b0,
                   mk(11'h437, 55'd1 << 54, 55'd0, 55, STK, 1'b0, 1'b0, 1'b0)};
        tbl[6] = '{11'h436, 11'h400, 52'd0, 52'd0, 1'b0, 1'b0, 1'b0,
                   mk(11'h436, 55'd1 << 54, 55'd1, 54, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[7] = '{11'h3FF, 11'h3FF, 52'd1, 52'd2, 1'b1, 1'b0, 1'b1,
                   mk(11'h3FF, (55'd1 << 54) | 55'd4, (55'd1 << 54) | 55'd8, 0, 1'b0, 1'b0, 1'b1, 1'b0)};
        tbl[8] = '{11'h000, 11'h002, 52'd3, 52'd0, 1'b0, 1'b0, 1'b0,
                   mk(11'h002, 55'd1 << 54, 55'd6, 1, 1'b0, 1'b1, 1'b0, 1'b0)};

        step(); step();
        @(negedge clk);
        chk1("reset_out_valid", out_valid, 0);
        chk1("reset_in_ready", in_ready, 1);
        chk("reset_data", got, '0);
        step();
        rst = 1'b0;

        // Directed vectors, one at a time, with latency measured from the accepting cycle.
        for (int i = 0; i < 9; i++) begin
            load(tbl[i]);
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            chk1($sformatf("vec%0d_accept", i), in_ready, 1);
            step();
            in_valid = 1'b0;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!out_valid && k < 10);
            chk1($sformatf("vec%0d_latency", i), k, 2);
            chk($sformatf("vec%0d", i), got, tbl[i].exp);
            step();
        end

        // Backpressure: two accepts fill the pipe, third pair waits, then all drain in order.
        out_ready = 1'b0; in_valid = 1'b1; acc = 0; rdy_last = 1;
        load(tbl[0]);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rdy_last = in_ready;
            if (in_valid && in_ready) acc++;
            step();
            load(tbl[acc]);
        end
        chk1("bp_accepts", acc, 2);
        chk1("bp_in_ready_low", rdy_last, 0);
        out_ready = 1'b1; fires = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_valid) fires++;
            if (in_valid && in_ready) begin
                step();
                in_valid = 1'b0;
            end else step();
        end
        chk1("bp_drain_consecutive", fires, 3);
        step(); step();

        clear_check(1'b1);
        clear_check(1'b0);

        // Random stream against the model with random stalls on both sides.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 7);
            ea = ($urandom_range(3) == 0) ? '0 : EXP_W'($urandom);
            off = $urandom_range(140);
            if (int'(ea) + int'(off) - 70 < 0 || int'(ea) + int'(off) - 70 > 2047 || $urandom_range(7) == 0)
                eb = EXP_W'($urandom_range(1));
            else
                eb = EXP_W'(int'(ea) + int'(off) - 70);
            fa = {$urandom, $urandom};
            fb = ($urandom_range(3) == 0) ? FRAC_W'($urandom_range(7)) : {$urandom, $urandom};
            sa = $urandom_range(1); sb = $urandom_range(1); sub = $urandom_range(1);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        @(negedge clk);
        chk1("random_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
